fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: NOP encoding, default reset PC,
// FSM state encoding and the {addr, inst} buffer entry.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {addr, inst} circular buffer with push/pop/flush.
// Ports: push_i/data_i in, pop_i, flush_i; valid_o/data_o head, count_o.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         valid_o,
  output fetch_entry_t data_o,
  output logic [2:0]   count_o
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [2:0]     count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + {2'b0, push_i}
                        - {2'b0, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign valid_o = (count_q != 3'd0);
  assign count_o = count_q;

  // Empty head presents a NOP at address 0.
  always_comb begin
    data_o.addr = '0;
    data_o.inst = NOP_INST;
    if (valid_o) data_o = mem_q[rptr_q];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads, buffers {addr, inst}, handles redirects.
// Ports: jump_*_i redirect, mem_* memory request/response, inst_* toward if_id.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [2:0]    outst_q, outst_d;
  logic [2:0]    drop_q, drop_d;
  logic [31:0]   aq_q [DEPTH];
  logic [AW-1:0] aq_w_q, aq_w_d;
  logic [AW-1:0] aq_r_q, aq_r_d;

  logic [2:0]    fifo_cnt;
  logic          can_issue, issue;
  logic          keep_iss, keep_rsp, pop;
  fetch_entry_t  fifo_in, fifo_out;

  // Pop/rvalid this cycle give no credit: current values only.
  assign can_issue = (state_q == RUN) &&
    (({1'b0, fifo_cnt} + {1'b0, outst_q}) < 4'(DEPTH));

  // An ungranted request keeps its address even across a jump.
  assign mem_req_o  = !rstn && (pend_q || can_issue);
  assign mem_addr_o = pend_q ? pend_addr_q : fetch_pc_q;
  assign issue      = mem_req_o && mem_gnt_i;

  assign keep_iss = issue && (state_q == RUN) && !jump_en_i;
  assign keep_rsp = mem_rvalid_i && (state_q == RUN) && !jump_en_i;
  assign pop      = inst_valid_o && inst_ready_i;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    pend_d      = mem_req_o && !mem_gnt_i;
    pend_addr_d = mem_addr_o;
    outst_d     = outst_q + {2'b0, issue}
                          - {2'b0, mem_rvalid_i};
    aq_w_d      = aq_w_q;
    aq_r_d      = aq_r_q;
    fetch_pc_d  = fetch_pc_q;

    // Grants in DRAIN are stale requests; pc already redirected.
    if (jump_en_i)
      fetch_pc_d = jump_addr_i & ~32'h3;
    else if (issue && (state_q == RUN))
      fetch_pc_d = fetch_pc_q + 32'd4;

    if (jump_en_i) begin
      aq_w_d = '0;
      aq_r_d = '0;
    end else begin
      if (keep_iss) aq_w_d = aq_w_q + 1'b1;
      if (keep_rsp) aq_r_d = aq_r_q + 1'b1;
    end

    unique case (1'b1)
      (state_q == RUN): begin
        if (jump_en_i) begin
          drop_d  = outst_d + {2'b0, pend_d};
          state_d = (drop_d != 3'd0) ? DRAIN : RUN;
        end
      end
      (state_q == DRAIN): begin
        drop_d = drop_q - {2'b0, mem_rvalid_i};
        if (drop_d == 3'd0) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      aq_w_q      <= '0;
      aq_r_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      aq_w_q      <= aq_w_d;
      aq_r_q      <= aq_r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (keep_iss) aq_q[aq_w_q] <= mem_addr_o;
  end

  assign fifo_in.addr = aq_q[aq_r_q];
  assign fifo_in.inst = mem_rdata_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (keep_rsp),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .flush_i (jump_en_i),
    .valid_o (inst_valid_o),
    .data_o  (fifo_out),
    .count_o (fifo_cnt)
  );

  assign inst_o      = fifo_out.inst;
  assign inst_addr_o = fifo_out.addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=4) with memory model
// and expected-address scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DEP = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  int          checks = 0;
  int          errors = 0;
  int          issued_cnt = 0;
  int          popped_cnt = 0;
  logic [31:0] last_iss = '0;
  logic        saw_200 = 1'b0;
  logic        rsp_en = 1'b1;
  logic [31:0] exp_q [$];
  logic [31:0] mq [$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk = ~clk;

  // Memory: in-order, 1-cycle latency, data = ~addr.
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      if (rstn) begin
        mq.delete();
      end else begin
        if (mem_rvalid_i) void'(mq.pop_front());
        if (mem_req_o && mem_gnt_i) begin
          mq.push_back(mem_addr_o);
          issued_cnt++;
          last_iss = mem_addr_o;
          if (mem_addr_o[31:8] == 24'h2) saw_200 = 1'b1;
        end
      end
      #2;
      mem_rvalid_i = !rstn && rsp_en && (mq.size() > 0);
      mem_rdata_i  = mem_rvalid_i ? ~mq[0] : '0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (inst_valid_o && inst_ready_i) begin
      popped_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra observed=%h expected=none", inst_addr_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", inst_addr_o, e);
        chk("sb_inst", inst_o, ~e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (inst_valid_o) break;
      tick();
    end
    chk(tag, inst_valid_o, 1'b1);
  endtask

  task automatic wait_issue(input string tag, input logic [31:0] a);
    int base;
    base = issued_cnt;
    for (int i = 0; i < 60; i++) begin
      if (issued_cnt != base) break;
      tick();
    end
    chk(tag, last_iss, a);
  endtask

  initial begin
    int snap;
    rstn = 1'b1;
    jump_en_i = 1'b0;
    jump_addr_i = '0;
    mem_gnt_i = 1'b1;
    inst_ready_i = 1'b1;
    ticks(2);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_iaddr", inst_addr_o, 32'h0);

    // Reset release: 0,4,8 on consecutive cycles.
    restart(32'h0);
    rstn = 1'b0;
    #1;
    chk("rel_req", mem_req_o, 1'b1);
    chk("rel_addr", mem_addr_o, 32'h0);
    tick();
    chk("c2_valid", inst_valid_o, 1'b0);
    tick();
    chk("c3_valid", inst_valid_o, 1'b1);
    chk("c3_addr", inst_addr_o, 32'h0);
    tick();
    chk("c4_addr", inst_addr_o, 32'h4);
    tick();
    chk("c5_addr", inst_addr_o, 32'h8);

    // Backpressure: buffer fills to DEPTH then requests stop.
    inst_ready_i = 1'b0;
    ticks(5);
    snap = issued_cnt;
    ticks(5);
    chk("bp_req", mem_req_o, 1'b0);
    chk("bp_noiss", issued_cnt, snap);
    chk("bp_held", issued_cnt - popped_cnt, DEP);
    inst_ready_i = 1'b1;
    snap = issued_cnt;
    ticks(3);
    chk("bp_resume", issued_cnt > snap, 1'b1);
    ticks(10);

    // Jump with exactly two outstanding and a half-full buffer.
    inst_ready_i = 1'b0;
    ticks(10);
    rsp_en = 1'b0;
    inst_ready_i = 1'b1;
    snap = issued_cnt;
    ticks(2);
    inst_ready_i = 1'b0;
    tick();
    chk("j1_outst", issued_cnt - snap, 2);
    chk("j1_noreq", mem_req_o, 1'b0);
    jump_en_i = 1'b1;
    jump_addr_i = 32'h100;
    tick();
    jump_en_i = 1'b0;
    restart(32'h100);
    chk("j1_flush", inst_valid_o, 1'b0);
    inst_ready_i = 1'b1;
    ticks(3);
    chk("j1_drain", mem_req_o, 1'b0);
    rsp_en = 1'b1;
    wait_issue("j1_first_iss", 32'h100);
    wait_valid("j1_valid");
    chk("j1_iaddr", inst_addr_o, 32'h100);
    ticks(8);

    // Jump 0x200, then 0x303 while draining: 0x300 wins.
    rsp_en = 1'b0;
    ticks(8);
    saw_200 = 1'b0;
    jump_en_i = 1'b1;
    jump_addr_i = 32'h200;
    tick();
    jump_addr_i = 32'h303;
    tick();
    jump_en_i = 1'b0;
    restart(32'h300);
    rsp_en = 1'b1;
    wait_issue("j2_first_iss", 32'h300);
    wait_valid("j2_valid");
    chk("j2_iaddr", inst_addr_o, 32'h300);
    ticks(10);
    chk("j2_no200", saw_200, 1'b0);

    // Reset pulse mid-stream.
    rstn = 1'b1;
    tick();
    chk("rp_req", mem_req_o, 1'b0);
    chk("rp_valid", inst_valid_o, 1'b0);
    chk("rp_inst", inst_o, NOP);
    chk("rp_iaddr", inst_addr_o, 32'h0);
    rstn = 1'b0;
    restart(32'h0);
    #1;
    chk("rp_rel_req", mem_req_o, 1'b1);
    chk("rp_rel_addr", mem_addr_o, 32'h0);

    // Grant stall at 8, with a jump while still stalled.
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o && mem_addr_o == 32'h8) break;
      tick();
    end
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("gs_req", mem_req_o, 1'b1);
      chk("gs_addr", mem_addr_o, 32'h8);
      if (i < 4) tick();
    end
    jump_en_i = 1'b1;
    jump_addr_i = 32'h400;
    tick();
    jump_en_i = 1'b0;
    restart(32'h400);
    chk("gsj_req", mem_req_o, 1'b1);
    chk("gsj_addr", mem_addr_o, 32'h8);
    mem_gnt_i = 1'b1;
    wait_valid("gsj_valid");
    chk("gsj_iaddr", inst_addr_o, 32'h400);
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
